// File: rtl/cpu_defs.sv
// Shared pipeline definitions: default datapath widths and the index of the
// architectural zero register. The pipeline stages and the register file use
// these so that everything stays in step.
package cpu_defs;

  // Default register data width.
  localparam int DATA_W_DEF = 32;

  // Default register address width (2**ADDR_W_DEF registers).
  localparam int ADDR_W_DEF = 5;

  // Index of the register that always reads as zero and ignores writes.
  localparam int REG_ZERO = 0;

  // Width of the committed-write counter.
  localparam int WCOUNT_W = 16;

  // True when a register address selects the zero register.
  function automatic logic is_reg_zero(input logic [ADDR_W_DEF-1:0] addr);
    return (addr == ADDR_W_DEF'(REG_ZERO));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file. It picks between the
// stored register value and the write-back data (write-through bypass), and
// forces zero for the zero register and while reset is held.
module regfile_read_port
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  // Read mux: reset and the zero register win, then a matching in-flight
  // write is forwarded, otherwise the stored value is returned.
  always_comb begin
    rd_data = '0;
    if (reset) begin
      rd_data = '0;
    end else if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = reg_data;
    end
  end

endmodule

// File: rtl/regfile_wb_rd.sv
// Register file written from the write-back stage and read by the decode
// stage. Two combinational read ports with write-through bypass, a hardwired
// zero register and a counter of committed writes.
module regfile_wb_rd
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   RegisterRd,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [ADDR_W-1:0]   RegisterRs,
  input  logic [ADDR_W-1:0]   RegisterRt,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic [WCOUNT_W-1:0] WriteCount
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [WCOUNT_W-1:0] write_count_q;
  logic [WCOUNT_W-1:0] write_count_d;
  logic                wr_en;
  logic [DATA_W-1:0]   rs_reg_data;
  logic [DATA_W-1:0]   rt_reg_data;

  // A write commits only for a definite RegWrite=1 to a non-zero register
  // outside reset; an unknown RegWrite falls to the no-write branch.
  always_comb begin
    wr_en = 1'b0;
    if ((RegWrite == 1'b1) && (RegisterRd != ADDR_W'(REG_ZERO)) && !Reset) begin
      wr_en = 1'b1;
    end
  end

  // Next array contents: the addressed register takes the write data and the
  // zero register is pinned to zero whatever happens.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[RegisterRd] = WriteData;
    end
    regs_d[REG_ZERO] = '0;
  end

  // Committed-write counter, wrapping naturally at its full width.
  always_comb begin
    write_count_d = write_count_q;
    if (wr_en) begin
      write_count_d = write_count_q + WCOUNT_W'(1);
    end
  end

  // State registers with asynchronous clear of the array and the counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  // Select the stored value for each read address before the bypass mux.
  always_comb begin
    rs_reg_data = regs_q[RegisterRs];
    rt_reg_data = regs_q[RegisterRt];
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .reset    (Reset),
    .rd_addr  (RegisterRs),
    .reg_data (rs_reg_data),
    .wr_en    (wr_en),
    .wr_addr  (RegisterRd),
    .wr_data  (WriteData),
    .rd_data  (ReadData1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .reset    (Reset),
    .rd_addr  (RegisterRt),
    .reg_data (rt_reg_data),
    .wr_en    (wr_en),
    .wr_addr  (RegisterRd),
    .wr_data  (WriteData),
    .rd_data  (ReadData2)
  );

  assign WriteCount = write_count_q;

endmodule

// File: tb/tb_regfile_wb_rd.sv
// Self-checking bench for regfile_wb_rd: directed scenarios plus randomized
// traffic, compared against a simple array-and-counter reference model.
module tb_regfile_wb_rd;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  RegisterRd;
  logic [31:0] WriteData;
  logic [4:0]  RegisterRs;
  logic [4:0]  RegisterRt;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [15:0] WriteCount;

  int          testsRun    = 0;
  int          testsFailed = 0;

  logic [31:0] modelRegs [32];
  int          modelCount;

  logic        rWe;
  logic [4:0]  rRd;
  logic [4:0]  rRs;
  logic [4:0]  rRt;
  logic [31:0] rWd;

  regfile_wb_rd dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
    .RegisterRd (RegisterRd),
    .WriteData  (WriteData),
    .RegisterRs (RegisterRs),
    .RegisterRt (RegisterRt),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .WriteCount (WriteCount)
  );

  // Free-running clock, 10 time units per period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference read: zero register reads 0, a pending write to the same
  // address is visible immediately, otherwise the stored model value.
  function automatic logic [31:0] modelRead(input logic [4:0] addr, input logic we,
                                            input logic [4:0] rd, input logic [31:0] wd);
    if (addr == 5'd0) return 32'h0;
    if (we && (rd == addr)) return wd;
    return modelRegs[addr];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
    modelCount = 0;
  endtask

  // Drive one cycle of inputs, check reads before and after the edge and the
  // write counter after the edge.
  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                               input logic [4:0] rs, input logic [4:0] rt, input string tag);
    @(negedge Clk);
    RegWrite   = we;
    RegisterRd = rd;
    WriteData  = wd;
    RegisterRs = rs;
    RegisterRt = rt;
    #1;
    checkOutput({tag, "_a_pre"}, ReadData1, modelRead(rs, we, rd, wd));
    checkOutput({tag, "_b_pre"}, ReadData2, modelRead(rt, we, rd, wd));
    @(posedge Clk);
    if (we && (rd != 5'd0)) begin
      modelRegs[rd] = wd;
      modelCount++;
    end
    #1;
    checkOutput({tag, "_a_post"}, ReadData1, modelRead(rs, we, rd, wd));
    checkOutput({tag, "_b_post"}, ReadData2, modelRead(rt, we, rd, wd));
    checkOutput({tag, "_count"}, {16'h0, WriteCount}, {16'h0, 16'(modelCount)});
  endtask

  // Assert reset between edges with a bypass-shaped write pending: reads must
  // be zero at once, and the write must not land across the held edge.
  task automatic applyReset(input string tag);
    @(negedge Clk);
    #2;
    Reset      = 1'b1;
    RegWrite   = 1'b1;
    RegisterRd = 5'd3;
    WriteData  = 32'hDEAD_BEEF;
    RegisterRs = 5'd3;
    RegisterRt = 5'd3;
    #1;
    checkOutput({tag, "_a"}, ReadData1, 32'h0);
    checkOutput({tag, "_b"}, ReadData2, 32'h0);
    checkOutput({tag, "_count"}, {16'h0, WriteCount}, 32'h0);
    @(posedge Clk);
    #1;
    checkOutput({tag, "_a_held"}, ReadData1, 32'h0);
    checkOutput({tag, "_count_held"}, {16'h0, WriteCount}, 32'h0);
    @(negedge Clk);
    Reset    = 1'b0;
    RegWrite = 1'b0;
    modelClear();
  endtask

  initial begin
    Reset      = 1'b0;
    RegWrite   = 1'b0;
    RegisterRd = 5'd0;
    WriteData  = 32'h0;
    RegisterRs = 5'd0;
    RegisterRt = 5'd0;
    modelClear();
    #1;
    Reset = 1'b1;
    #2;
    checkOutput("reset_a", ReadData1, 32'h0);
    checkOutput("reset_b", ReadData2, 32'h0);
    checkOutput("reset_count", {16'h0, WriteCount}, 32'h0);
    applyReset("reset_bypass");

    // Register 3 must still be empty after the write attempted under reset.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "after_reset");

    // Basic write then read.
    applyStimulus(1'b1, 5'd5, 32'h0000_FFFF, 5'd0, 5'd0, "wr5");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, "rd5");
    checkOutput("rd5_value", ReadData1, 32'h0000_FFFF);
    checkOutput("rd5_count", {16'h0, WriteCount}, 32'd1);

    // Writes to the zero register are discarded.
    applyStimulus(1'b1, 5'd0, 32'h0000_1111, 5'd0, 5'd0, "x0");
    checkOutput("x0_count", {16'h0, WriteCount}, 32'd1);

    // Write-through bypass on both ports.
    applyStimulus(1'b1, 5'd7, 32'h0000_AAAA, 5'd0, 5'd0, "wr7");
    applyStimulus(1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd7, "byp7");
    checkOutput("byp7_value", ReadData2, 32'h0000_1234);

    // RegWrite low must never commit.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd9, 32'h0000_FFFF, 5'd9, 5'd9, "nowr9");
    checkOutput("nowr9_value", ReadData1, 32'h0);

    // Randomized traffic, read addresses biased towards the write address.
    for (int i = 0; i < 400; i++) begin
      rWe = 1'($urandom_range(0, 1));
      rRd = 5'($urandom_range(0, 31));
      rWd = $urandom;
      rRs = ($urandom_range(0, 3) == 0) ? rRd : 5'($urandom_range(0, 31));
      rRt = ($urandom_range(0, 3) == 0) ? rRd : 5'($urandom_range(0, 31));
      applyStimulus(rWe, rRd, rWd, rRs, rRt, "rand");
    end

    // Fill every register, then reset mid-operation.
    for (int n = 1; n < 32; n++)
      applyStimulus(1'b1, 5'(n), 32'hCCCC_0000 + 32'(n), 5'(n - 1), 5'(n), "fill");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd17, "fill_rd");
    @(negedge Clk);
    #2;
    Reset    = 1'b1;
    RegWrite = 1'b0;
    for (int a = 0; a < 32; a++) begin
      RegisterRs = 5'(a);
      RegisterRt = 5'(31 - a);
      #1;
      checkOutput("midreset_a", ReadData1, 32'h0);
      checkOutput("midreset_b", ReadData2, 32'h0);
    end
    checkOutput("midreset_count", {16'h0, WriteCount}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    modelClear();

    // First edge after release commits normally.
    applyStimulus(1'b1, 5'd12, 32'h5A5A_0012, 5'd12, 5'd1, "resume");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd1, "resume_rd");

    // Counter wrap: 65536 committed writes after reset.
    applyReset("wrap_reset");
    for (int i = 0; i < 65535; i++) begin
      @(negedge Clk);
      rRd        = 5'($urandom_range(1, 31));
      rWd        = $urandom;
      RegWrite   = 1'b1;
      RegisterRd = rRd;
      WriteData  = rWd;
      modelRegs[rRd] = rWd;
      modelCount++;
    end
    @(negedge Clk);
    RegWrite = 1'b0;
    #1;
    checkOutput("wrap_ffff", {16'h0, WriteCount}, 32'h0000_FFFF);
    applyStimulus(1'b1, 5'd4, 32'h0BAD_F00D, 5'd4, 5'd0, "wrap_last");
    checkOutput("wrap_zero", {16'h0, WriteCount}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rRs = 5'($urandom_range(0, 31));
      rRt = 5'($urandom_range(0, 31));
      applyStimulus(1'b0, 5'd0, 32'h0, rRs, rRt, "wrap_rd");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
